enemy_kill_serializer: RTL and testbench

ENEMY_KILL_SERIALIZER -- requirements
Module: enemy_kill_serializer

---
 rtl/enemy_kill_serializer_pkg.sv | 20 ++
 rtl/enemy_kill_serializer_if.sv | 22 ++
 rtl/enemy_kill_serializer_lsb_priority_enc.sv | 23 ++
 rtl/enemy_kill_serializer.sv | 109 ++++++++++
 tb/tb_enemy_kill_serializer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/enemy_kill_serializer_pkg.sv
// Shared fly/enemy game definitions: slot count, coordinate width, index width,
// serializer state encoding and flat-bus packing helper.
package enemy_kill_serializer_pkg;

  localparam int N_ENEMY_DEF = 17;
  localparam int COORD_W_DEF = 10;
  localparam int CNT_W_DEF   = 8;
  localparam int IDX_W       = 5;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } ser_state_e;

  // Low bit of slot i inside a flat bus packed as [i*w +: w].
  function automatic int slot_lo(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/enemy_kill_serializer_if.sv
// Kill-event handshake between the serializer (master) and the fly controller (slave).
interface enemy_kill_serializer_if
  import enemy_kill_serializer_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
);
  logic               kill_valid;
  logic               kill_ready;
  logic [IDX_W-1:0]   kill_idx;
  logic [COORD_W-1:0] kill_x;
  logic [COORD_W-1:0] kill_y;

  modport master (
    output kill_valid, kill_idx, kill_x, kill_y,
    input  kill_ready
  );

  modport slave (
    input  kill_valid, kill_idx, kill_x, kill_y,
    output kill_ready
  );
endinterface

// File: rtl/enemy_kill_serializer_lsb_priority_enc.sv
// Combinational lowest-set-bit encoder: index of the lowest asserted bit plus a found flag.
module lsb_priority_enc #(
  parameter int N     = 17,
  parameter int IDX_W = 5
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enemy_kill_serializer.sv
// Latches per-slot enemy hits and offers them one at a time, lowest slot first,
// to the fly controller over a valid/ready handshake.
//
//   state   | meaning
//   S_IDLE  | no event offered; waits for a registered pending bit
//   S_OFFER | kill_valid high; idx/x/y held until kill_ready
module enemy_kill_serializer
  import enemy_kill_serializer_pkg::*;
#(
  parameter int N_ENEMY = N_ENEMY_DEF,
  parameter int COORD_W = COORD_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_ENEMY-1:0]         enemy_hit_flat,
  input  logic [N_ENEMY-1:0]         enemy_alive_flat,
  input  logic [N_ENEMY*COORD_W-1:0] enemy_x_flat,
  input  logic [N_ENEMY*COORD_W-1:0] enemy_y_flat,
  enemy_kill_serializer_if.master    kill,
  output logic [N_ENEMY-1:0]         pending_flat,
  output logic [CNT_W-1:0]           kill_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ser_state_e         state;
  logic [N_ENEMY-1:0] hit_q;
  logic [N_ENEMY-1:0] accept_mask;
  logic [N_ENEMY-1:0] pending_nxt;
  logic [N_ENEMY-1:0] sel_vec;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;
  logic [COORD_W-1:0] sel_x;
  logic [COORD_W-1:0] sel_y;
  logic               accept;

  assign hit_q       = enemy_hit_flat & enemy_alive_flat;
  assign accept      = (state == S_OFFER) && kill.kill_ready;
  assign accept_mask = accept ? (N_ENEMY'(1) << kill.kill_idx) : '0;
  // Clearing after the OR merges a same-cycle re-hit of the accepted slot.
  assign pending_nxt = (pending_flat | hit_q) & ~accept_mask;

  // IDLE picks from registered pending only; OFFER chains straight from pending_nxt.
  assign sel_vec = (state == S_OFFER) ? pending_nxt : pending_flat;

  lsb_priority_enc #(
    .N     (N_ENEMY),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec   (sel_vec),
    .idx   (sel_idx),
    .found (sel_found)
  );

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_x = enemy_x_flat[slot_lo(i, COORD_W) +: COORD_W];
        sel_y = enemy_y_flat[slot_lo(i, COORD_W) +: COORD_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      kill.kill_valid <= 1'b0;
      kill.kill_idx   <= '0;
      kill.kill_x     <= '0;
      kill.kill_y     <= '0;
      pending_flat    <= '0;
      kill_count      <= '0;
    end else begin
      pending_flat <= pending_nxt;
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            state           <= S_OFFER;
            kill.kill_valid <= 1'b1;
            kill.kill_idx   <= sel_idx;
            kill.kill_x     <= sel_x;
            kill.kill_y     <= sel_y;
          end
        end
        S_OFFER: begin
          if (kill.kill_ready) begin
            if (kill_count != CNT_MAX) kill_count <= kill_count + 1'b1;
            if (sel_found) begin
              kill.kill_idx <= sel_idx;
              kill.kill_x   <= sel_x;
              kill.kill_y   <= sel_y;
            end else begin
              state           <= S_IDLE;
              kill.kill_valid <= 1'b0;
            end
          end
        end
        default: begin
          state           <= S_IDLE;
          kill.kill_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_kill_serializer.sv
// Bench for enemy_kill_serializer: directed scenarios plus randomized traffic against a set-based model.
module tb_enemy_kill_serializer;

  localparam int N  = 17;
  localparam int CW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    hit;
  logic [N-1:0]    alive;
  logic [N*CW-1:0] xf;
  logic [N*CW-1:0] yf;
  logic [N-1:0]    pending;
  logic [7:0]      count;

  enemy_kill_serializer_if #(.COORD_W(CW)) kif ();

  enemy_kill_serializer #(.N_ENEMY(N), .COORD_W(CW), .CNT_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .enemy_hit_flat   (hit),
    .enemy_alive_flat (alive),
    .enemy_x_flat     (xf),
    .enemy_y_flat     (yf),
    .kill             (kif),
    .pending_flat     (pending),
    .kill_count       (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: set of pending slots, the current offer (if any) and an accept count.
  bit       m_pend [N];
  bit       m_valid;
  int       m_idx, m_x, m_y, m_cnt;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pend_bits();
    int v = 0;
    for (int i = 0; i < N; i++) if (m_pend[i]) v |= (1 << i);
    return v;
  endfunction

  task automatic offer_lowest(input bit src [N]);
    m_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (src[i]) begin
        m_valid = 1'b1;
        m_idx   = i;
        m_x     = int'(xf[i*CW +: CW]);
        m_y     = int'(yf[i*CW +: CW]);
        break;
      end
    end
  endtask

  task automatic model_step();
    bit old [N];
    if (rst) begin
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_valid = 1'b0; m_idx = 0; m_x = 0; m_y = 0; m_cnt = 0;
      return;
    end
    old = m_pend;
    for (int i = 0; i < N; i++) if (hit[i] && alive[i]) m_pend[i] = 1'b1;
    if (m_valid && kif.kill_ready) begin
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_pend[m_idx] = 1'b0;
      offer_lowest(m_pend);
    end else if (!m_valid) begin
      offer_lowest(old);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("valid", kif.kill_valid, m_valid);
      check("pending", pending, pend_bits());
      check("count", count, m_cnt);
      if (m_valid) begin
        check("idx", kif.kill_idx, m_idx);
        check("x", kif.kill_x, m_x);
        check("y", kif.kill_y, m_y);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_xy(input int i, input int x, input int y);
    xf[i*CW +: CW] = CW'(x);
    yf[i*CW +: CW] = CW'(y);
  endtask

  initial begin
    rst = 1'b1; hit = '0; alive = '0; xf = '0; yf = '0; kif.kill_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_valid", kif.kill_valid, 0);
    check("rst_pending", pending, 0);
    check("rst_count", count, 0);
    check("rst_idx", kif.kill_idx, 0);
    rst = 1'b0;
    tick();

    // Single hit on slot 3.
    alive = '1; kif.kill_ready = 1'b1; set_xy(3, 100, 50); hit = 17'd1 << 3;
    tick();
    hit = '0;
    check("s3_pend", pending, 17'd1 << 3);
    check("s3_early", kif.kill_valid, 0);
    tick();
    check("s3_valid", kif.kill_valid, 1);
    check("s3_idx", kif.kill_idx, 3);
    check("s3_x", kif.kill_x, 100);
    check("s3_y", kif.kill_y, 50);
    tick();
    check("s3_drop", kif.kill_valid, 0);
    check("s3_cnt", count, 1);

    // Simultaneous hits 0, 7, 16.
    hit = (17'd1 << 0) | (17'd1 << 7) | (17'd1 << 16);
    tick();
    hit = '0;
    tick(); check("m_idx0", kif.kill_idx, 0);
    tick(); check("m_idx7", kif.kill_idx, 7);
    tick(); check("m_idx16", kif.kill_idx, 16);
    check("m_model_cnt", m_cnt, 3);
    tick();
    check("m_valid", kif.kill_valid, 0);
    check("m_cnt", count, 4);
    check("m_pend", pending, 0);

    // Back-pressure on slot 5 while its x moves.
    kif.kill_ready = 1'b0; set_xy(5, 200, 60); hit = 17'd1 << 5;
    tick();
    hit = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      set_xy(5, 300 + k, 70 + k);
      tick();
      check("bp_valid", kif.kill_valid, 1);
      check("bp_idx", kif.kill_idx, 5);
      check("bp_x", kif.kill_x, 200);
      check("bp_y", kif.kill_y, 60);
    end
    kif.kill_ready = 1'b1;
    tick();
    check("bp_done", kif.kill_valid, 0);
    check("bp_cnt", count, 5);

    // Dead-slot hit and repeat hit on a pending slot.
    alive = ~(17'd1 << 9); hit = 17'd1 << 9;
    tick();
    hit = '0;
    check("dead_pend", pending, 0);
    tick();
    check("dead_valid", kif.kill_valid, 0);
    alive = '1; kif.kill_ready = 1'b0; hit = 17'd1 << 2;
    tick();
    hit = '0;
    tick();
    check("rep_idx", kif.kill_idx, 2);
    hit = 17'd1 << 2;
    tick();
    hit = '0;
    check("rep_pend", pending, 17'd1 << 2);
    kif.kill_ready = 1'b1;
    tick();
    check("rep_valid", kif.kill_valid, 0);
    check("rep_cnt", count, 6);
    tick();
    check("rep_once", kif.kill_valid, 0);

    // Randomized traffic.
    for (int c = 0; c < 2500; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      hit   = N'($urandom & $urandom & $urandom);
      alive = N'(~($urandom & $urandom & $urandom));
      xf    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      yf    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      kif.kill_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;

    // Saturation: continuous hits on every slot with ready held high.
    alive = '1; hit = '1; kif.kill_ready = 1'b1;
    for (int c = 0; c < 320; c++) tick();
    check("sat_cnt", count, 255);
    check("sat_model", m_cnt, 255);
    check("sat_offer", kif.kill_valid, 1);

    // Reset while offering, with hits present in the reset cycle.
    rst = 1'b1;
    tick();
    check("rst_mid_valid", kif.kill_valid, 0);
    check("rst_mid_pend", pending, 0);
    check("rst_mid_cnt", count, 0);
    rst = 1'b0; hit = '0;
    tick();
    check("post_rst_pend", pending, 0);
    check("post_rst_valid", kif.kill_valid, 0);
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
